// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: opcodes, flag bit positions,
// control FSM states and the flag-packing helper.
package alu_pkg;

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_AND = 3'b010;
   localparam logic [2:0] OP_OR  = 3'b011;
   localparam logic [2:0] OP_XOR = 3'b100;
   localparam logic [2:0] OP_SHL = 3'b101;
   localparam logic [2:0] OP_SHR = 3'b110;
   localparam logic [2:0] OP_MUL = 3'b111;

   localparam int BAND_Z = 0;
   localparam int BAND_C = 1;
   localparam int BAND_N = 2;

   typedef enum logic [1:0] {
      REPOSO = 2'd0,
      MULT   = 2'd1,
      FIN    = 2'd2
   } estado_t;

   // Places the Z/C/N bits at their fixed positions in the flag vector.
   function automatic logic [2:0] empaqueta_banderas(input logic z, input logic c, input logic n);
      logic [2:0] b;
      b         = 3'b000;
      b[BAND_Z] = z;
      b[BAND_C] = c;
      b[BAND_N] = n;
      return b;
   endfunction

endpackage

// File: rtl/alu_multiplicador.sv
// Serial shift-add unsigned multiplier: one partial product per clock,
// WIDTH iterations after the load edge.
module alu_multiplicador
   import alu_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic [WIDTH-1:0]     X,
   input  logic [WIDTH-1:0]     Y,
   output logic                 busy,
   output logic                 done,
   output logic [2*WIDTH-1:0]   product
);

   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] CNT_INI = CW'(WIDTH);
   localparam logic [CW-1:0] CNT_UNO = CW'(1);

   logic [2*WIDTH-1:0] acc_r;
   logic [WIDTH-1:0]   mcand_r;
   logic [CW-1:0]      cnt_r;
   logic [WIDTH:0]     suma_s;
   logic [2*WIDTH-1:0] acc_sig_s;

   // Next accumulator: add multiplicand into the high half when the LSB is set, then shift right.
   always_comb begin
      suma_s    = {1'b0, acc_r[2*WIDTH-1:WIDTH]} + (acc_r[0] ? {1'b0, mcand_r} : {(WIDTH+1){1'b0}});
      acc_sig_s = {suma_s, acc_r[WIDTH-1:1]};
   end

   // done/product are combinational so the caller can register the result on the final iteration edge.
   assign done    = busy && (cnt_r == CNT_UNO);
   assign product = acc_sig_s;

   // Operand load on start, one iteration per clock while busy.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_r   <= {(2*WIDTH){1'b0}};
         mcand_r <= {WIDTH{1'b0}};
         cnt_r   <= {CW{1'b0}};
         busy    <= 1'b0;
      end else if (start) begin
         acc_r   <= {{WIDTH{1'b0}}, Y};
         mcand_r <= X;
         cnt_r   <= CNT_INI;
         busy    <= 1'b1;
      end else if (busy) begin
         acc_r <= acc_sig_s;
         cnt_r <= cnt_r - CNT_UNO;
         if (cnt_r == CNT_UNO) begin
            busy <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/alu_secuencial.sv
// Registered ALU with start/busy/done handshake: single-cycle add/sub/logic/shift
// and a WIDTH-cycle serial multiplier sequenced by a small control FSM.
module alu_secuencial
   import alu_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic              i_Clk,
   input  logic              i_Rst_n,
   input  logic              i_Hab,
   input  logic [2:0]        i_Inst_decodificada,
   input  logic [WIDTH-1:0]  i_RX,
   input  logic [WIDTH-1:0]  i_RY,
   output logic [WIDTH-1:0]  o_Resultado,
   output logic [WIDTH-1:0]  o_Resultado_Alto,
   output logic [2:0]        o_Bandera,
   output logic              o_Ocupado,
   output logic              o_Listo
);

   estado_t            estado_r;
   logic [SHW-1:0]     sh_s;
   logic [WIDTH:0]     suma_s;
   logic [WIDTH:0]     resta_s;
   logic [WIDTH:0]     shl_s;
   logic [WIDTH:0]     shr_s;
   logic [WIDTH-1:0]   res_s;
   logic               carry_s;
   logic               start_s;
   logic               mul_busy_s;
   logic               mul_done_s;
   logic [2*WIDTH-1:0] mul_prod_s;

   assign sh_s    = i_RY[SHW-1:0];
   assign start_s = (estado_r == REPOSO) && i_Hab && (i_Inst_decodificada == OP_MUL);

   // Single-cycle datapath; the extra top/bottom bit of each shift captures the last bit shifted out.
   always_comb begin
      suma_s  = {1'b0, i_RX} + {1'b0, i_RY};
      resta_s = {1'b0, i_RX} - {1'b0, i_RY};
      shl_s   = {1'b0, i_RX} << sh_s;
      shr_s   = {i_RX, 1'b0} >> sh_s;
      res_s   = {WIDTH{1'b0}};
      carry_s = 1'b0;
      case (i_Inst_decodificada)
         OP_ADD: begin
            res_s   = suma_s[WIDTH-1:0];
            carry_s = suma_s[WIDTH];
         end
         OP_SUB: begin
            res_s   = resta_s[WIDTH-1:0];
            carry_s = resta_s[WIDTH];
         end
         OP_AND: res_s = i_RX & i_RY;
         OP_OR:  res_s = i_RX | i_RY;
         OP_XOR: res_s = i_RX ^ i_RY;
         OP_SHL: begin
            res_s   = shl_s[WIDTH-1:0];
            carry_s = (sh_s != {SHW{1'b0}}) ? shl_s[WIDTH] : 1'b0;
         end
         OP_SHR: begin
            res_s   = shr_s[WIDTH:1];
            carry_s = (sh_s != {SHW{1'b0}}) ? shr_s[0] : 1'b0;
         end
         default: begin
            res_s   = {WIDTH{1'b0}};
            carry_s = 1'b0;
         end
      endcase
   end

   alu_multiplicador #(
      .WIDTH (WIDTH)
   ) u_mult (
      .clk     (i_Clk),
      .rst_n   (i_Rst_n),
      .start   (start_s),
      .X       (i_RX),
      .Y       (i_RY),
      .busy    (mul_busy_s),
      .done    (mul_done_s),
      .product (mul_prod_s)
   );

   // Control FSM with registered results, flags and handshake outputs.
   always_ff @(posedge i_Clk or negedge i_Rst_n) begin
      if (!i_Rst_n) begin
         estado_r         <= REPOSO;
         o_Resultado      <= {WIDTH{1'b0}};
         o_Resultado_Alto <= {WIDTH{1'b0}};
         o_Bandera        <= 3'b000;
         o_Ocupado        <= 1'b0;
         o_Listo          <= 1'b0;
      end else begin
         case (estado_r)
            REPOSO: begin
               o_Listo <= 1'b0;
               if (i_Hab) begin
                  if (i_Inst_decodificada == OP_MUL) begin
                     o_Ocupado <= 1'b1;
                     estado_r  <= MULT;
                  end else begin
                     o_Resultado      <= res_s;
                     o_Resultado_Alto <= {WIDTH{1'b0}};
                     o_Bandera        <= empaqueta_banderas(res_s == {WIDTH{1'b0}}, carry_s,
                                                            res_s[WIDTH-1]);
                     o_Listo          <= 1'b1;
                     estado_r         <= FIN;
                  end
               end
            end
            MULT: begin
               if (mul_done_s) begin
                  o_Resultado      <= mul_prod_s[WIDTH-1:0];
                  o_Resultado_Alto <= mul_prod_s[2*WIDTH-1:WIDTH];
                  o_Bandera        <= empaqueta_banderas(mul_prod_s == {(2*WIDTH){1'b0}},
                                                         mul_prod_s[2*WIDTH-1:WIDTH] != {WIDTH{1'b0}},
                                                         mul_prod_s[WIDTH-1]);
                  o_Ocupado        <= 1'b0;
                  o_Listo          <= 1'b1;
                  estado_r         <= FIN;
               end else if (!mul_busy_s) begin
                  // Engine idle without finishing: abandon the operation rather than wait forever.
                  o_Ocupado <= 1'b0;
                  estado_r  <= REPOSO;
               end
            end
            FIN: begin
               o_Listo  <= 1'b0;
               estado_r <= REPOSO;
            end
            default: begin
               o_Ocupado <= 1'b0;
               o_Listo   <= 1'b0;
               estado_r  <= REPOSO;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_secuencial.sv
// Randomized self-checking bench for alu_secuencial (WIDTH=8) against an
// arithmetic reference model of the opcode/flag rules.
module tb_alu_secuencial;

   localparam int WIDTH = 8;

   logic             i_Clk = 1'b0;
   logic             i_Rst_n;
   logic             i_Hab;
   logic [2:0]       i_Inst_decodificada;
   logic [WIDTH-1:0] i_RX;
   logic [WIDTH-1:0] i_RY;
   logic [WIDTH-1:0] o_Resultado;
   logic [WIDTH-1:0] o_Resultado_Alto;
   logic [2:0]       o_Bandera;
   logic             o_Ocupado;
   logic             o_Listo;

   int n_checks = 0;
   int n_fail   = 0;

   alu_secuencial #(.WIDTH(WIDTH)) dut (
      .i_Clk               (i_Clk),
      .i_Rst_n             (i_Rst_n),
      .i_Hab               (i_Hab),
      .i_Inst_decodificada (i_Inst_decodificada),
      .i_RX                (i_RX),
      .i_RY                (i_RY),
      .o_Resultado         (o_Resultado),
      .o_Resultado_Alto    (o_Resultado_Alto),
      .o_Bandera           (o_Bandera),
      .o_Ocupado           (o_Ocupado),
      .o_Listo             (o_Listo)
   );

   always #5 i_Clk = ~i_Clk;

   task automatic comprobar(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Reference: plain integer arithmetic; flags returned as {N,C,Z}.
   task automatic modelo(input int op, input int x, input int y,
                         output int res, output int alto, output int band);
      int s, c, z, p;
      s = y % WIDTH;
      c = 0;
      alto = 0;
      case (op)
         0: begin res = (x + y) % 256; c = (x + y > 255) ? 1 : 0; end
         1: begin res = (x - y + 256) % 256; c = (x < y) ? 1 : 0; end
         2: res = x & y;
         3: res = x | y;
         4: res = x ^ y;
         5: begin res = (x * (1 << s)) % 256; c = (s != 0) ? (x / (1 << (WIDTH - s))) % 2 : 0; end
         6: begin res = x / (1 << s); c = (s != 0) ? (x / (1 << (s - 1))) % 2 : 0; end
         default: begin
            p = x * y;
            res = p % 256;
            alto = p / 256;
            c = (alto != 0) ? 1 : 0;
         end
      endcase
      if (op == 7) z = (x * y == 0) ? 1 : 0;
      else         z = (res == 0) ? 1 : 0;
      band = ((res / 128) % 2) * 4 + c * 2 + z;
   endtask

   // Launches one operation from REPOSO and checks latency, handshake and results.
   task automatic ejecutar(input int op, input int x, input int y, input bit inyectar);
      int res, alto, band, lat, ocu;
      modelo(op, x, y, res, alto, band);
      i_Hab = 1'b1;
      i_Inst_decodificada = op[2:0];
      i_RX = x[7:0];
      i_RY = y[7:0];
      @(posedge i_Clk); #1;
      i_Hab = 1'b0;
      i_RX = 8'($urandom);
      i_RY = 8'($urandom);
      if (op == 7) begin
         lat = 0;
         ocu = 0;
         while (!o_Listo && lat < 20) begin
            if (o_Ocupado) ocu++;
            i_Hab = inyectar && (lat == 3);
            i_Inst_decodificada = 3'd0;
            @(posedge i_Clk); #1;
            lat++;
         end
         i_Hab = 1'b0;
         comprobar("mul_latency", lat, WIDTH);
         comprobar("mul_busy_cycles", ocu, WIDTH);
      end
      comprobar($sformatf("listo op%0d", op), int'(o_Listo), 1);
      comprobar($sformatf("ocupado op%0d", op), int'(o_Ocupado), 0);
      comprobar($sformatf("res op%0d x=%0h y=%0h", op, x, y), int'(o_Resultado), res);
      comprobar($sformatf("alto op%0d x=%0h y=%0h", op, x, y), int'(o_Resultado_Alto), alto);
      comprobar($sformatf("band op%0d x=%0h y=%0h", op, x, y), int'(o_Bandera), band);
      @(posedge i_Clk); #1;
      comprobar("listo_one_pulse", int'(o_Listo), 0);
      comprobar("res_hold", int'(o_Resultado), res);
   endtask

   initial begin
      i_Rst_n = 1'b0;
      i_Hab = 1'b0;
      i_Inst_decodificada = 3'd0;
      i_RX = 8'h00;
      i_RY = 8'h00;
      #12;
      comprobar("rst_res", int'(o_Resultado), 0);
      comprobar("rst_alto", int'(o_Resultado_Alto), 0);
      comprobar("rst_band", int'(o_Bandera), 0);
      comprobar("rst_ocupado", int'(o_Ocupado), 0);
      comprobar("rst_listo", int'(o_Listo), 0);
      @(negedge i_Clk);
      i_Rst_n = 1'b1;
      @(posedge i_Clk); #1;

      ejecutar(0, 8'h0F, 8'h01, 1'b0);
      ejecutar(1, 8'h01, 8'h0F, 1'b0);
      ejecutar(1, 8'h01, 8'h01, 1'b0);
      ejecutar(5, 8'h81, 8'h01, 1'b0);
      ejecutar(6, 8'h81, 8'h00, 1'b0);
      ejecutar(6, 8'h81, 8'h01, 1'b0);
      ejecutar(0, 8'hFF, 8'h01, 1'b0);
      ejecutar(7, 8'hFF, 8'hFF, 1'b0);
      ejecutar(7, 8'h0F, 8'h11, 1'b0);
      ejecutar(7, 8'h00, 8'h5A, 1'b0);

      // A start strobe during MUL must be dropped.
      ejecutar(7, 8'h23, 8'h45, 1'b1);
      for (int i = 0; i < 3; i++) begin
         i_RX = 8'($urandom);
         i_RY = 8'($urandom);
         @(posedge i_Clk); #1;
         comprobar("idle_no_listo", int'(o_Listo), 0);
         comprobar("idle_res_hold", int'(o_Resultado), 'h23 * 'h45 % 256);
      end

      for (int i = 0; i < 60; i++) begin
         ejecutar(int'($urandom_range(0, 7)), int'($urandom_range(0, 255)),
                  int'($urandom_range(0, 255)), 1'b0);
      end

      // Strobe held high: a new single-cycle op every second cycle.
      i_Hab = 1'b1;
      i_Inst_decodificada = 3'd0;
      i_RX = 8'h03;
      i_RY = 8'h04;
      for (int i = 0; i < 6; i++) begin
         @(posedge i_Clk); #1;
         comprobar("hab_held_listo", int'(o_Listo), (i % 2 == 0) ? 1 : 0);
         comprobar("hab_held_res", int'(o_Resultado), 7);
      end
      i_Hab = 1'b0;

      // Reset in the middle of a multiply.
      ejecutar(0, 8'h0F, 8'h01, 1'b0);
      i_Hab = 1'b1;
      i_Inst_decodificada = 3'd7;
      i_RX = 8'hFF;
      i_RY = 8'hFF;
      @(posedge i_Clk); #1;
      i_Hab = 1'b0;
      repeat (4) begin
         @(posedge i_Clk); #1;
      end
      comprobar("pre_rst_ocupado", int'(o_Ocupado), 1);
      #2;
      i_Rst_n = 1'b0;
      #1;
      comprobar("midrst_res", int'(o_Resultado), 0);
      comprobar("midrst_alto", int'(o_Resultado_Alto), 0);
      comprobar("midrst_band", int'(o_Bandera), 0);
      comprobar("midrst_ocupado", int'(o_Ocupado), 0);
      comprobar("midrst_listo", int'(o_Listo), 0);
      repeat (2) begin
         @(posedge i_Clk); #1;
         comprobar("midrst_no_listo", int'(o_Listo), 0);
      end
      @(negedge i_Clk);
      i_Rst_n = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(posedge i_Clk); #1;
         comprobar("post_rst_no_listo", int'(o_Listo), 0);
      end
      ejecutar(0, 8'h0F, 8'h01, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule

// File: doc/alu_secuencial.md
Name: alu_secuencial

Overview:
Parametrised, registered successor to the 8-bit combinational ALU of the UAZ microcontroller datapath. Single-cycle ops (add, sub, logic, shift) plus a multi-cycle serial shift-add multiplier. Start/busy/done handshake lets the control unit launch an operation and wait for completion. Sits between the register file (RX, RY operands) and the writeback mux.

Parameters:
WIDTH, 8, operand/result width in bits (>=4).
SHW, $clog2(WIDTH), width of shift-amount field taken from i_RY[SHW-1:0].

Ports:
i_Clk  input  1  system clock, rising edge.
i_Rst_n  input  1  asynchronous active-low reset.
i_Hab  input  1  start strobe; sampled only in REPOSO.
i_Inst_decodificada  input  3  opcode; sampled with i_Hab.
i_RX  input  WIDTH  operand X; sampled with i_Hab.
i_RY  input  WIDTH  operand Y; sampled with i_Hab.
o_Resultado  output  WIDTH  result, low half for MUL.
o_Resultado_Alto  output  WIDTH  high half of MUL product; 0 for other ops.
o_Bandera  output  3  flags: [0]=Z, [1]=C, [2]=N.
o_Ocupado  output  1  high while a MUL is in progress.
o_Listo  output  1  one-cycle pulse when results/flags update.

Behaviour:
- Reset (async, i_Rst_n=0): state REPOSO, o_Resultado=0, o_Resultado_Alto=0, o_Bandera=3'b000, o_Ocupado=0, o_Listo=0, multiplier counter/accumulators=0. Reset mid-MUL aborts it with no o_Listo.
- Opcodes: 000 ADD, 001 SUB (X-Y), 010 AND, 011 OR, 100 XOR, 101 SHL (X << Y[SHW-1:0]), 110 SHR logical, 111 MUL unsigned.
- States: REPOSO, MULT, FIN.
- REPOSO with i_Hab=1 at edge k:
  - Ops 000-110: result and flags registered at edge k; FIN entered. o_Listo=1 during cycle k..k+1 (latency 1). Return to REPOSO at edge k+1.
  - MUL: operands loaded, counter=WIDTH, o_Ocupado=1, state MULT.
- MULT: one shift-add iteration per edge. After the WIDTH-th iteration (edge k+WIDTH), product written to o_Resultado/o_Resultado_Alto, flags updated, o_Ocupado=0, state FIN. o_Listo pulses in the following cycle. Total latency WIDTH.
- FIN: o_Listo=1 for exactly one cycle; unconditional return to REPOSO. i_Hab is ignored in FIN.
- i_Hab in MULT or FIN: ignored, no queuing. i_Hab held high continuously relaunches from REPOSO every 2 cycles (single-cycle ops).
- Outputs hold their last values between operations; operand changes while idle have no effect.
- Flags:
  - Z=(o_Resultado==0); for MUL, Z=(full 2*WIDTH product==0).
  - N=o_Resultado[WIDTH-1].
  - C per op:
    - ADD: carry out.
    - SUB: borrow (X<Y unsigned).
    - AND/OR/XOR: 0.
    - SHL: last bit shifted out of MSB. SHR: last bit shifted out of LSB. Shift amount 0 gives C=0.
    - MUL: 1 if o_Resultado_Alto!=0.
- Arithmetic is modulo 2^WIDTH. o_Resultado_Alto=0 for all non-MUL ops.

Decomposition:
- alu_pkg:
  - Opcode localparams (OP_ADD..OP_MUL).
  - Flag bit indices (BAND_Z=0, BAND_C=1, BAND_N=2).
  - State encoding (REPOSO, MULT, FIN).
- Sub-module alu_multiplicador:
  - Serial shift-add engine, parametrised WIDTH.
  - Ports: clk, rst_n, start, X, Y, busy, done, product[2*WIDTH-1:0].
  - Instantiated once; the top FSM sequences it and registers outputs.

Test Plan (WIDTH=8):
- ADD X=0x0F, Y=0x01, pulse i_Hab -> next cycle o_Listo=1, o_Resultado=0x10, o_Bandera=000, o_Ocupado never high.
- SUB X=0x01, Y=0x0F -> o_Resultado=0xF2, o_Bandera=110 (N=1, C=1). SUB X=Y=0x01 -> 0x00, o_Bandera=001.
- SHL X=0x81, Y=0x01 -> o_Resultado=0x02, C=1. SHR X=0x81, Y=0x00 -> 0x81, o_Bandera=100.
- MUL X=0xFF, Y=0xFF -> o_Ocupado high for 8 cycles, then o_Listo pulse; o_Resultado=0x01, o_Resultado_Alto=0xFE, o_Bandera=010. MUL X=0x0F, Y=0x11 -> 0xFF, alto 0x00, o_Bandera=100.
- During MUL, pulse i_Hab with ADD opcode -> ignored; final result still the MUL product; exactly one o_Listo pulse.
- Assert i_Rst_n=0 at MUL cycle 4 -> all outputs 0 immediately (asynchronously); no o_Listo. A subsequent ADD 0x0F+0x01 completes normally.
